// File: rtl/dual_port_mem_controller_pkg.sv
// ============================================================================
//  Module : dual_port_mem_controller_pkg
//  Brief  : Shared sizing helpers for the memory controller and future LSQ blocks.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dual_port_mem_controller_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Port-index width; a single port still needs one bit to hold index 0.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dual_port_mem_controller_rr_arbiter.sv
// ============================================================================
//  Module : rr_arbiter
//  Brief  : Combinational round-robin arbiter, search starts at ptr.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          gnt_valid
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt       = '0;
      idx       = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dual_port_mem_controller.sv
// ============================================================================
//  Module : dual_port_mem_controller
//  Brief  : Arbitrates load ports onto RAM port 0 and store ports onto port 1.
//           Optional macro MEM_CTRL_STATS_EN adds ld_count/st_count outputs.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dual_port_mem_controller
   import dual_port_mem_controller_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int LOAD_COUNT  = 2,
   parameter int STORE_COUNT = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [LOAD_COUNT*ADDR_WIDTH-1:0]  ld_addr,
   input  logic [LOAD_COUNT-1:0]             ld_addr_valid,
   output logic [LOAD_COUNT-1:0]             ld_addr_ready,
   output logic [LOAD_COUNT*DATA_WIDTH-1:0]  ld_data,
   output logic [LOAD_COUNT-1:0]             ld_data_valid,
   input  logic [LOAD_COUNT-1:0]             ld_data_ready,
   input  logic [STORE_COUNT*ADDR_WIDTH-1:0] st_addr,
   input  logic [STORE_COUNT*DATA_WIDTH-1:0] st_data,
   input  logic [STORE_COUNT-1:0]            st_valid,
   output logic [STORE_COUNT-1:0]            st_ready,
   input  logic                              end_valid,
   output logic                              end_ready,
   output logic                              ce0,
   output logic                              we0,
   output logic [ADDR_WIDTH-1:0]             address0,
   output logic [DATA_WIDTH-1:0]             mem_din0,
   input  logic [DATA_WIDTH-1:0]             mem_dout0,
   output logic                              ce1,
   output logic                              we1,
   output logic [ADDR_WIDTH-1:0]             address1,
   output logic [DATA_WIDTH-1:0]             mem_din1,
   output logic                              done
`ifdef MEM_CTRL_STATS_EN
   ,output logic [31:0]                      ld_count
   ,output logic [31:0]                      st_count
`endif
);

   localparam int LIW = idx_width(LOAD_COUNT);
   localparam int SIW = idx_width(STORE_COUNT);

   logic [LIW-1:0]         ld_ptr, ld_idx, infl_idx;
   logic                   infl_valid, ld_gnt_valid;
   logic [LOAD_COUNT-1:0]  ld_elig, ld_gnt;
   logic [SIW-1:0]         st_ptr, st_idx;
   logic                   st_gnt_valid;
   logic [STORE_COUNT-1:0] st_gnt;
   logic                   quiet;

   // A port may issue only if its buffer has room when the read data lands.
   always_comb begin
      ld_elig = '0;
      for (int i = 0; i < LOAD_COUNT; i++) begin
         ld_elig[i] = ld_addr_valid[i]
                    & ~(infl_valid & (infl_idx == LIW'(i)))
                    & (~ld_data_valid[i] | ld_data_ready[i]);
      end
   end

   rr_arbiter #(.N(LOAD_COUNT), .IW(LIW)) u_ld_arb (
      .req       (ld_elig),
      .ptr       (ld_ptr),
      .gnt       (ld_gnt),
      .idx       (ld_idx),
      .gnt_valid (ld_gnt_valid)
   );

   rr_arbiter #(.N(STORE_COUNT), .IW(SIW)) u_st_arb (
      .req       (st_valid),
      .ptr       (st_ptr),
      .gnt       (st_gnt),
      .idx       (st_idx),
      .gnt_valid (st_gnt_valid)
   );

   assign ld_addr_ready = ld_gnt;
   assign ce0           = ld_gnt_valid;
   assign we0           = 1'b0;
   assign mem_din0      = '0;
   assign address0      = ld_addr[int'(ld_idx)*ADDR_WIDTH +: ADDR_WIDTH];

   assign st_ready      = st_gnt;
   assign ce1           = st_gnt_valid;
   assign we1           = st_gnt_valid;
   assign address1      = st_addr[int'(st_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign mem_din1      = st_data[int'(st_idx)*DATA_WIDTH +: DATA_WIDTH];

   assign quiet     = ~|ld_addr_valid & ~|st_valid & ~infl_valid & ~|ld_data_valid;
   assign end_ready = done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_ptr     <= '0;
         st_ptr     <= '0;
         infl_valid <= 1'b0;
         infl_idx   <= '0;
         done       <= 1'b0;
      end else begin
         infl_valid <= ld_gnt_valid;
         infl_idx   <= ld_idx;
         if (ld_gnt_valid)
            ld_ptr <= (int'(ld_idx) == LOAD_COUNT - 1) ? '0 : ld_idx + 1'b1;
         if (st_gnt_valid)
            st_ptr <= (int'(st_idx) == STORE_COUNT - 1) ? '0 : st_idx + 1'b1;
         if (!end_valid)
            done <= 1'b0;
         else if (quiet)
            done <= 1'b1;
      end
   end

   // Capture has priority over drain so a same-edge refill keeps the buffer full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_data_valid <= '0;
         ld_data       <= '0;
      end else begin
         for (int i = 0; i < LOAD_COUNT; i++) begin
            if (infl_valid && (infl_idx == LIW'(i))) begin
               ld_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem_dout0;
               ld_data_valid[i]                    <= 1'b1;
            end else if (ld_data_ready[i]) begin
               ld_data_valid[i] <= 1'b0;
            end
         end
      end
   end

`ifdef MEM_CTRL_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_count <= '0;
         st_count <= '0;
      end else begin
         if (ld_gnt_valid) ld_count <= ld_count + 32'd1;
         if (st_gnt_valid) st_count <= st_count + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_port_mem_controller.sv
// ============================================================================
//  Module : tb_dual_port_mem_controller
//  Brief  : Self-checking bench with a two-port RAM model and load scoreboard.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dual_port_mem_controller;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int LC    = 2;
   localparam int SC    = 1;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [LC*AW-1:0]  ld_addr;
   logic [LC-1:0]     ld_addr_valid, ld_addr_ready, ld_data_valid, ld_data_ready;
   logic [LC*DW-1:0]  ld_data;
   logic [SC*AW-1:0]  st_addr;
   logic [SC*DW-1:0]  st_data;
   logic [SC-1:0]     st_valid, st_ready;
   logic              end_valid, end_ready, done;
   logic              ce0, we0, ce1, we1;
   logic [AW-1:0]     address0, address1;
   logic [DW-1:0]     mem_din0, mem_din1;
   logic [DW-1:0]     mem_dout0 = '0;
`ifdef MEM_CTRL_STATS_EN
   logic [31:0]       ld_count, st_count;
`endif

   int total = 0;
   int bad   = 0;

   dual_port_mem_controller #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .LOAD_COUNT (LC), .STORE_COUNT (SC)
   ) dut (
      .clk (clk), .rst (rst),
      .ld_addr (ld_addr), .ld_addr_valid (ld_addr_valid), .ld_addr_ready (ld_addr_ready),
      .ld_data (ld_data), .ld_data_valid (ld_data_valid), .ld_data_ready (ld_data_ready),
      .st_addr (st_addr), .st_data (st_data), .st_valid (st_valid), .st_ready (st_ready),
      .end_valid (end_valid), .end_ready (end_ready),
      .ce0 (ce0), .we0 (we0), .address0 (address0), .mem_din0 (mem_din0), .mem_dout0 (mem_dout0),
      .ce1 (ce1), .we1 (we1), .address1 (address1), .mem_din1 (mem_din1),
      .done (done)
`ifdef MEM_CTRL_STATS_EN
      ,.ld_count (ld_count), .st_count (st_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Two-port RAM model: registered read on port 0, write on port 1, write-to-read forwarding.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) ram[k] <= 32'h1000 + k;
         ram[5] <= 32'hAB;
      end else begin
         if (ce1 && we1 && address1 < DEPTH) ram[address1[3:0]] <= mem_din1;
         if (ce0 && address0 < DEPTH)
            mem_dout0 <= (ce1 && we1 && address1 == address0) ? mem_din1 : ram[address0[3:0]];
      end
   end

   // Scoreboard: expectation pushed at load grant, compared when the consumer drains.
   logic [DW-1:0] shadow [DEPTH];
   logic [DW-1:0] exp_q0[$], exp_q1[$];
   int            gq[$];
   always @(negedge clk) begin
      logic [AW-1:0] a;
      logic [DW-1:0] e;
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) shadow[k] = 32'h1000 + k;
         shadow[5] = 32'hAB;
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         for (int i = 0; i < LC; i++) begin
            if (ld_addr_ready[i]) begin
               a = ld_addr[i*AW +: AW];
               e = (st_ready[0] && st_addr == a) ? st_data : shadow[a[3:0]];
               if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
               gq.push_back(i);
            end
         end
         if (st_ready[0]) shadow[st_addr[3:0]] = st_data;
         if (ld_data_valid[0] && ld_data_ready[0]) begin
            if (exp_q0.size() == 0) check("sb_q0_nonempty", 64'(exp_q0.size()), 1);
            else check("sb_ld0_data", ld_data[0 +: DW], exp_q0.pop_front());
         end
         if (ld_data_valid[1] && ld_data_ready[1]) begin
            if (exp_q1.size() == 0) check("sb_q1_nonempty", 64'(exp_q1.size()), 1);
            else check("sb_ld1_data", ld_data[DW +: DW], exp_q1.pop_front());
         end
      end
   end

   typedef struct {
      int            port;
      logic [AW-1:0] addr;
      logic [DW-1:0] exp;
   } ld_vec_t;

   ld_vec_t tbl[5];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int gcnt;
      tbl[0] = '{0, 32'd5,  32'hAB};
      tbl[1] = '{1, 32'd5,  32'hAB};
      tbl[2] = '{1, 32'd0,  32'h1000};
      tbl[3] = '{0, 32'd15, 32'h100F};
      tbl[4] = '{1, 32'd7,  32'h1007};

      rst = 1'b1; ld_addr = '0; ld_addr_valid = '0; ld_data_ready = '1;
      st_addr = '0; st_data = '0; st_valid = '0; end_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ld_data_valid", ld_data_valid, 0);
      check("rst_ld_addr_ready", ld_addr_ready, 0);
      check("rst_st_ready", st_ready, 0);
      check("rst_ce_we", {ce0, we0, ce1, we1}, 0);
      check("rst_done", {done, end_ready}, 0);
      rst = 1'b0;
      next_cyc();

      // Single loads: grant in the issue cycle, data exactly two cycles later.
      for (int v = 0; v < 5; v++) begin
         p = tbl[v].port;
         ld_addr[p*AW +: AW] = tbl[v].addr;
         ld_addr_valid[p]    = 1'b1;
         #3;
         check("tbl_grant", ld_addr_ready, 64'(1) << p);
         check("tbl_address0", address0, tbl[v].addr);
         next_cyc();
         ld_addr_valid = '0;
         check("tbl_lat1_not_valid", ld_data_valid[p], 0);
         next_cyc();
         check("tbl_valid", ld_data_valid[p], 1);
         check("tbl_data", ld_data[p*DW +: DW], tbl[v].exp);
         next_cyc();
      end

      // Contention: pointer rests at port 0 after the last port-1 load.
      ld_addr = {32'd2, 32'd1};
      ld_addr_valid = 2'b11;
      gq.delete();
      gcnt = 0;
      for (int c = 0; c < 8; c++) begin
         #3;
         check("cont_onehot", 64'($countones(ld_addr_ready)), 1);
         next_cyc();
      end
      ld_addr_valid = '0;
      check("cont_grants", 64'(gq.size()), 8);
      for (int k = 0; k < gq.size(); k++) check("cont_order", 64'(gq[k]), 64'(k % 2));
      repeat (4) next_cyc();

      // Backpressure on port 0: data held, second address waits for the drain.
      ld_data_ready[0] = 1'b0;
      ld_addr[0 +: AW] = 32'd5;
      ld_addr_valid[0] = 1'b1;
      #3 check("bp_grant1", ld_addr_ready[0], 1);
      next_cyc();
      ld_addr[0 +: AW] = 32'd6;
      #3 check("bp_inflight_block", ld_addr_ready[0], 0);
      next_cyc();
      for (int c = 0; c < 3; c++) begin
         check("bp_valid_held", ld_data_valid[0], 1);
         check("bp_data_held", ld_data[0 +: DW], 32'hAB);
         #3 check("bp_no_grant", ld_addr_ready[0], 0);
         next_cyc();
      end
      ld_data_ready[0] = 1'b1;
      #3 check("bp_grant2", ld_addr_ready[0], 1);
      next_cyc();
      ld_addr_valid[0] = 1'b0;
      check("bp_drained", ld_data_valid[0], 0);
      next_cyc();
      check("bp_second_valid", ld_data_valid[0], 1);
      check("bp_second_data", ld_data[0 +: DW], 32'h1006);
      next_cyc();

      // Store then load one cycle later.
      st_addr = 32'd3; st_data = 32'h55; st_valid = 1'b1;
      #3;
      check("st_ready", st_ready, 1);
      check("st_ce_we", {ce1, we1, address1[3:0]}, {2'b11, 4'd3});
      next_cyc();
      st_valid = 1'b0;
      ld_addr[0 +: AW] = 32'd3; ld_addr_valid[0] = 1'b1;
      next_cyc();
      ld_addr_valid = '0;
      next_cyc();
      check("st_then_ld_data", ld_data[0 +: DW], 32'h55);
      next_cyc();

      // Store and load to the same address in the same cycle.
      st_addr = 32'd4; st_data = 32'h55; st_valid = 1'b1;
      ld_addr[AW +: AW] = 32'd4; ld_addr_valid[1] = 1'b1;
      #3 check("same_cyc_grants", {st_ready, ld_addr_ready}, 3'b110);
      next_cyc();
      st_valid = 1'b0; ld_addr_valid = '0;
      next_cyc();
      check("same_cyc_ld_data", ld_data[DW +: DW], 32'h55);
      next_cyc();

      // done waits for the port-1 buffer to drain.
      ld_data_ready[1] = 1'b0;
      ld_addr[AW +: AW] = 32'd2; ld_addr_valid[1] = 1'b1;
      next_cyc();
      ld_addr_valid = '0;
      next_cyc();
      end_valid = 1'b1;
      check("end_buf_full", ld_data_valid[1], 1);
      next_cyc();
      check("end_done_blocked1", done, 0);
      next_cyc();
      check("end_done_blocked2", {done, end_ready}, 0);
      ld_data_ready[1] = 1'b1;
      next_cyc();
      next_cyc();
      check("end_done_set", {done, end_ready}, 2'b11);
      end_valid = 1'b0;
      next_cyc();
      check("end_done_clear", done, 0);
      next_cyc();

      // Reset with one load buffered and another in flight.
      ld_data_ready[1] = 1'b0;
      ld_addr = {32'd7, 32'd5};
      ld_addr_valid = 2'b10;
      next_cyc();
      ld_addr_valid = 2'b01;
      next_cyc();
      ld_addr_valid = '0;
      check("rst_mid_pre_valid", ld_data_valid, 2'b10);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", ld_data_valid, 0);
      check("rst_mid_ce", {ce0, ce1, we1, done}, 0);
      next_cyc();
      next_cyc();
      rst = 1'b0;
      ld_data_ready = '1;
      for (int c = 0; c < 4; c++) begin
         check("rst_no_replay", ld_data_valid, 0);
         next_cyc();
      end
      ld_addr_valid = 2'b11;
      #3 check("rst_ptr_port0", ld_addr_ready, 2'b01);
      next_cyc();
      ld_addr_valid = '0;
      repeat (5) next_cyc();
      check("sb_all_drained", 64'(exp_q0.size() + exp_q1.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
